// File: rtl/gpio_irq_sequencer.sv
// APB master for one GPIO block: programs its config registers on request and
// turns GPIO interrupts into {status, data} events on a valid/ready port.
module gpio_irq_sequencer #(
  parameter int          NUM_PINS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [NUM_PINS-1:0] cfg_en,
  input  logic [NUM_PINS-1:0] cfg_intr_en,
  input  logic [NUM_PINS-1:0] cfg_pos,
  input  logic [NUM_PINS-1:0] cfg_neg,
  output logic                cfg_busy,
  output logic                cfg_done,
  input  logic                gpio_intr,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [NUM_PINS-1:0] evt_stat,
  output logic [NUM_PINS-1:0] evt_data,
  output logic [31:0]         PADDR,
  output logic [31:0]         PWDATA,
  output logic                PWRITE,
  output logic                PSEL,
  output logic                PENABLE,
  input  logic [31:0]         PRDATA
);

  localparam logic [31:0] OFF_DATA = 32'h04, OFF_EN  = 32'h08, OFF_INTR_EN = 32'h0C,
                          OFF_POS  = 32'h10, OFF_NEG = 32'h14, OFF_CLR     = 32'h18,
                          OFF_STAT = 32'h1C;

  typedef enum logic [3:0] {
    IDLE, CFG_SETUP, CFG_ACCESS, STAT_SETUP, STAT_ACCESS,
    CLR_SETUP, CLR_ACCESS, DATA_SETUP, DATA_ACCESS, EVT
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          cfg_idx;
  logic [NUM_PINS-1:0] en_q, ien_q, pos_q, neg_q, stat_q, data_q;
  logic                done_q;
  logic [31:0]         off;
  logic [NUM_PINS-1:0] wval;
  logic [NUM_PINS-1:0] rd_pins;
  logic                unused_prdata;

  assign rd_pins       = PRDATA[NUM_PINS-1:0];
  assign unused_prdata = ^PRDATA;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_idx <= '0;
      en_q    <= '0;
      ien_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      stat_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == CFG_ACCESS) && (cfg_idx == 3'd4);
      case (state)
        IDLE: if (cfg_start) begin
          cfg_idx <= '0;
          en_q    <= cfg_en;
          ien_q   <= cfg_intr_en;
          pos_q   <= cfg_pos;
          neg_q   <= cfg_neg;
        end
        CFG_ACCESS:  cfg_idx <= cfg_idx + 3'd1;
        STAT_ACCESS: stat_q  <= rd_pins;
        DATA_ACCESS: data_q  <= rd_pins;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    off       = '0;
    wval      = '0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PADDR     = '0;
    PWDATA    = '0;
    case (state)
      IDLE: begin
        if (cfg_start)      state_nxt = CFG_SETUP;
        else if (gpio_intr) state_nxt = STAT_SETUP;
      end
      CFG_SETUP:   state_nxt = CFG_ACCESS;
      CFG_ACCESS:  state_nxt = (cfg_idx == 3'd4) ? IDLE : CFG_SETUP;
      STAT_SETUP:  state_nxt = STAT_ACCESS;
      // A zero status means nothing to acknowledge: skip clear and event.
      STAT_ACCESS: state_nxt = (rd_pins == '0) ? IDLE : CLR_SETUP;
      CLR_SETUP:   state_nxt = CLR_ACCESS;
      CLR_ACCESS:  state_nxt = DATA_SETUP;
      DATA_SETUP:  state_nxt = DATA_ACCESS;
      DATA_ACCESS: state_nxt = EVT;
      EVT:         if (evt_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase

    // Interrupt enable goes last so stale status is cleared before it can fire.
    case (state)
      CFG_SETUP, CFG_ACCESS: begin
        PWRITE = 1'b1;
        case (cfg_idx)
          3'd0:    begin off = OFF_EN;      wval = en_q;  end
          3'd1:    begin off = OFF_POS;     wval = pos_q; end
          3'd2:    begin off = OFF_NEG;     wval = neg_q; end
          3'd3:    begin off = OFF_CLR;     wval = '1;    end
          default: begin off = OFF_INTR_EN; wval = ien_q; end
        endcase
      end
      STAT_SETUP, STAT_ACCESS: off = OFF_STAT;
      CLR_SETUP, CLR_ACCESS: begin
        PWRITE = 1'b1;
        off    = OFF_CLR;
        wval   = stat_q;
      end
      DATA_SETUP, DATA_ACCESS: off = OFF_DATA;
      default: ;
    endcase

    PSEL    = (state != IDLE) && (state != EVT);
    PENABLE = (state == CFG_ACCESS) || (state == STAT_ACCESS) ||
              (state == CLR_ACCESS) || (state == DATA_ACCESS);
    if (PSEL) PADDR = BASE_ADDR + off;
    if (PWRITE) PWDATA[NUM_PINS-1:0] = wval;
  end

  assign cfg_busy  = (state == CFG_SETUP) || (state == CFG_ACCESS);
  assign cfg_done  = done_q;
  assign evt_valid = (state == EVT);
  assign evt_stat  = stat_q;
  assign evt_data  = data_q;

endmodule
